sha256_nonce_sweeper: RTL

//  Producer/consumer on the far side of sha256_doublehash_core: builds 640-bit headers, feeds them to the core, reads digests.

---
 rtl/sha256_miner_pkg.sv | 57 +++++
 rtl/sha256_doublehash_core.sv | 77 +++++++
 rtl/sha256_nonce_sweeper.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/sha256_miner_pkg.sv
// Shared types, constants and helpers for the nonce sweeper and its
// double-SHA-256 core.
//   HDR_W / DIGEST_W  : header and digest widths
//   NONCE_LSB         : bit position of the nonce field in the header
//   NBITS_LSB         : bit position of the compact target field (header order)
//   state_t           : sweeper FSM states
//   SHA_K / SHA_IV    : SHA-256 round constants and initial hash value
//   bswap32/bswap256  : byte reversal; nbits_to_target: compact target expansion
package sha256_miner_pkg;

  localparam int HDR_W     = 640;
  localparam int DIGEST_W  = 256;
  localparam int NONCE_LSB = 0;
  localparam int NBITS_LSB = 32;

  typedef enum logic [1:0] {IDLE, LOAD, RUN, CHECK} state_t;

  localparam logic [31:0] SHA_K [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};

  // Element 0 is H0 and sits at the MSB end of the packed vector.
  localparam logic [0:7][31:0] SHA_IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bswap32(input logic [31:0] x);
    return {x[7:0], x[15:8], x[23:16], x[31:24]};
  endfunction

  function automatic logic [255:0] bswap256(input logic [255:0] x);
    logic [255:0] r;
    for (int i = 0; i < 32; i++) r[8*i +: 8] = x[255-8*i -: 8];
    return r;
  endfunction

  // Compact difficulty: exponent is a byte count, mantissa is 24 bits.
  function automatic logic [255:0] nbits_to_target(input logic [31:0] nbits);
    logic [255:0] mant;
    int           e;
    mant = {232'd0, nbits[23:0]};
    e    = int'(nbits[31:24]);
    if (e <= 3) return mant >> (8 * (3 - e));
    else        return mant << (8 * (e - 3));
  endfunction

endpackage

// File: rtl/sha256_doublehash_core.sv
// Iterative double SHA-256 of a 640-bit header: SHA256(SHA256(header)).
// One round per cycle; each block costs 66 cycles (load, 64 rounds, add),
// three blocks in total, so the digest is stable 198 cycles after rst
// falls and is held until rst rises again. header_i must stay stable.
//   clk, rst  : clock; asynchronous active-high reset (restarts the hash)
//   header_i  : 640-bit header, first byte at the MSB end
//   digest_o  : {H0..H7} of the second pass (first digest byte at MSB)
module sha256_doublehash_core
  import sha256_miner_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic [HDR_W-1:0]    header_i,
  output logic [DIGEST_W-1:0] digest_o
);

  logic [1:0]        blk_q;   // 0,1: header blocks; 2: second pass; 3: finished
  logic [6:0]        st_q;    // 0 load, 1..64 rounds, 65 chaining add
  logic [0:7][31:0]  hv_q;
  logic [0:7][31:0]  v_q;
  logic [0:15][31:0] w_q;     // sliding message-schedule window, w_q[0] = W[t]

  logic [511:0]      msg;
  logic [0:7][31:0]  v_rnd;
  logic [31:0]       t1, t2, w_new;
  logic [5:0]        kidx;

  // Padded message blocks: 80-byte header spans two blocks, the 32-byte
  // first digest fits in one.
  always_comb begin
    case (blk_q)
      2'd0:    msg = header_i[639:128];
      2'd1:    msg = {header_i[127:0], 1'b1, 319'd0, 64'd640};
      default: msg = {hv_q, 1'b1, 191'd0, 64'd256};
    endcase
  end

  always_comb begin
    kidx  = st_q[5:0] - 6'd1;
    t1    = v_q[7] + (rotr(v_q[4], 6) ^ rotr(v_q[4], 11) ^ rotr(v_q[4], 25))
          + ((v_q[4] & v_q[5]) ^ (~v_q[4] & v_q[6])) + SHA_K[kidx] + w_q[0];
    t2    = (rotr(v_q[0], 2) ^ rotr(v_q[0], 13) ^ rotr(v_q[0], 22))
          + ((v_q[0] & v_q[1]) ^ (v_q[0] & v_q[2]) ^ (v_q[1] & v_q[2]));
    v_rnd = {t1 + t2, v_q[0:2], v_q[3] + t1, v_q[4:6]};
    w_new = (rotr(w_q[14], 17) ^ rotr(w_q[14], 19) ^ (w_q[14] >> 10)) + w_q[9]
          + (rotr(w_q[1], 7) ^ rotr(w_q[1], 18) ^ (w_q[1] >> 3)) + w_q[0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      blk_q <= '0;
      st_q  <= '0;
      hv_q  <= SHA_IV;
      v_q   <= '0;
      w_q   <= '0;
    end else if (blk_q != 2'd3) begin
      if (st_q == 7'd0) begin
        // Second pass restarts from the IV; msg still sees the old hv_q.
        v_q  <= (blk_q == 2'd2) ? SHA_IV : hv_q;
        if (blk_q == 2'd2) hv_q <= SHA_IV;
        w_q  <= msg;
        st_q <= 7'd1;
      end else if (st_q == 7'd65) begin
        for (int i = 0; i < 8; i++) hv_q[i] <= hv_q[i] + v_q[i];
        st_q  <= 7'd0;
        blk_q <= blk_q + 2'd1;
      end else begin
        v_q  <= v_rnd;
        w_q  <= {w_q[1:15], w_new};
        st_q <= st_q + 7'd1;
      end
    end
  end

  assign digest_o = hv_q;

endmodule

// File: rtl/sha256_nonce_sweeper.sv
// Mining control: sweeps a nonce range over a latched base header, runs the
// double-SHA core once per nonce and stops at the first digest whose
// byte-reversed value is <= target, or when the range is exhausted.
// Build option: define TARGET_FROM_NBITS_EN to derive the target from the
// header's compact nBits field instead of the target port.
//   clk, reset          : clock; asynchronous active-high reset
//   start, abort        : launch (IDLE only) / stop a sweep
//   header_base         : header; bits [31:0] replaced by the nonce
//   nonce_start/_end    : inclusive nonce range, wraps through 0xFFFFFFFF
//   target              : numeric target (unused with TARGET_FROM_NBITS_EN)
//   busy, done          : sweep in progress / 1-cycle end pulse
//   found, found_nonce, found_digest : winning result (sticky until start)
//   attempts            : nonces fully evaluated this sweep
module sha256_nonce_sweeper
  import sha256_miner_pkg::*;
#(
  parameter int HASH_LATENCY = 220
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                abort,
  input  logic [HDR_W-1:0]    header_base,
  input  logic [31:0]         nonce_start,
  input  logic [31:0]         nonce_end,
  input  logic [255:0]        target,
  output logic                busy,
  output logic                done,
  output logic                found,
  output logic [31:0]         found_nonce,
  output logic [DIGEST_W-1:0] found_digest,
  output logic [31:0]         attempts
);

  localparam int CNT_W = (HASH_LATENCY > 1) ? $clog2(HASH_LATENCY) : 1;

  state_t                  state_q, state_d;
  logic [HDR_W-1:NONCE_LSB+32] hdr_q;
  logic [31:0]             nonce_q, nonce_end_q, attempts_q, found_nonce_q;
  logic [CNT_W-1:0]        cnt_q;
  logic                    done_q, found_q;
  logic [DIGEST_W-1:0]     found_digest_q, core_digest;
  logic [255:0]            eff_target, hash_le;
  logic [HDR_W-1:0]        core_hdr;
  logic                    core_rst, accept, hit, last_nonce, cnt_last;
  logic                    unused_ok;

  assign accept     = (state_q == IDLE) && start && !abort;
  assign hash_le    = bswap256(core_digest);
  assign hit        = (hash_le <= eff_target);
  assign last_nonce = (nonce_q == nonce_end_q);
  assign cnt_last   = (cnt_q == CNT_W'(HASH_LATENCY - 1));

`ifdef TARGET_FROM_NBITS_EN
  assign eff_target = nbits_to_target(bswap32(hdr_q[NBITS_LSB+31:NBITS_LSB]));
  assign unused_ok  = ^{header_base[31:0], target};
`else
  logic [255:0] target_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset)       target_q <= '0;
    else if (accept) target_q <= target;
  end
  assign eff_target = target_q;
  assign unused_ok  = ^header_base[31:0];
`endif

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Next state; abort overrides every busy-state transition
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (start && !abort) state_d = LOAD;
      LOAD:  state_d = abort ? IDLE : RUN;
      RUN:   if (abort) state_d = IDLE;
             else if (cnt_last) state_d = CHECK;
      CHECK: state_d = (abort || hit || last_nonce) ? IDLE : LOAD;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs: the core restarts in LOAD and idles in reset
  always_comb begin
    busy     = (state_q != IDLE);
    core_rst = (state_q == IDLE) || (state_q == LOAD);
    core_hdr = {hdr_q, bswap32(nonce_q)};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hdr_q          <= '0;
      nonce_q        <= '0;
      nonce_end_q    <= '0;
      cnt_q          <= '0;
      done_q         <= 1'b0;
      found_q        <= 1'b0;
      found_nonce_q  <= '0;
      found_digest_q <= '0;
      attempts_q     <= '0;
    end else begin
      done_q <= 1'b0;
      if (accept) begin
        hdr_q       <= header_base[HDR_W-1:NONCE_LSB+32];
        nonce_q     <= nonce_start;
        nonce_end_q <= nonce_end;
        found_q     <= 1'b0;
        attempts_q  <= '0;
      end else if (busy && abort) begin
        done_q  <= 1'b1;
        found_q <= 1'b0;
      end else begin
        if (state_q == LOAD)     cnt_q <= '0;
        else if (state_q == RUN) cnt_q <= cnt_q + 1'b1;
        if (state_q == CHECK) begin
          attempts_q <= attempts_q + 32'd1;
          if (hit) begin
            found_q        <= 1'b1;
            found_nonce_q  <= nonce_q;
            found_digest_q <= core_digest;
            done_q         <= 1'b1;
          end else if (last_nonce) begin
            done_q <= 1'b1;
          end else begin
            nonce_q <= nonce_q + 32'd1;
          end
        end
      end
    end
  end

  sha256_doublehash_core u_core (
    .clk      (clk),
    .rst      (core_rst),
    .header_i (core_hdr),
    .digest_o (core_digest)
  );

  assign done         = done_q;
  assign found        = found_q;
  assign found_nonce  = found_nonce_q;
  assign found_digest = found_digest_q;
  assign attempts     = attempts_q;

endmodule
